note_lane_renderer: RTL and testbench

- Parametrised successor to the fixed 10-square lane painter.
- On a `start` pulse, it takes a snapshot of the red and yellow note sequences. It then rasterises NUM_SLOTS squares of SQ_SIZE x SQ_SIZE pixels, one pixel per clock, into the VGA adapter's plot interface.
- It sits between the note shifters and the VGA adapter. The game controller drives it once per frame tick.

---
 rtl/note_lane_renderer_if.sv | 24 ++
 rtl/note_lane_renderer.sv | 167 ++++++++++++++++
 tb/tb_note_lane_renderer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/note_lane_renderer_if.sv
// Plot-side bus of the note lane renderer: frame request, note snapshots in, VGA pixel writes out.
interface note_lane_renderer_if #(
  parameter int unsigned NUM_SLOTS = 10
);
  logic                 start;
  logic [NUM_SLOTS-1:0] red_sequence;
  logic [NUM_SLOTS-1:0] yellow_sequence;
  logic                 busy;
  logic                 done;
  logic                 plot;
  logic [7:0]           x;
  logic [6:0]           y;
  logic [2:0]           colour;

  modport master (
    output start, red_sequence, yellow_sequence,
    input  busy, done, plot, x, y, colour
  );

  modport slave (
    input  start, red_sequence, yellow_sequence,
    output busy, done, plot, x, y, colour
  );
endinterface

// File: rtl/note_lane_renderer.sv
// Rasterises NUM_SLOTS note squares into the VGA plot interface, one pixel per clock.
// Optional NOTE_LANE_DIFF_EN: skip slots whose colour is unchanged since the last frame.
module note_lane_renderer #(
  parameter int unsigned NUM_SLOTS = 10,
  parameter int unsigned SQ_SIZE   = 4,
  parameter int unsigned X_START   = 10,
  parameter int unsigned X_PITCH   = 10,
  parameter int unsigned Y_POS     = 112
) (
  input  logic                 clk,
  input  logic                 resetn,
  note_lane_renderer_if.slave  bus
);

  if (NUM_SLOTS < 1 || NUM_SLOTS > 16 || SQ_SIZE < 1 || SQ_SIZE > 8 || X_PITCH < SQ_SIZE
      || X_START + (NUM_SLOTS - 1) * X_PITCH + SQ_SIZE - 1 > 159
      || Y_POS + SQ_SIZE - 1 > 119) begin : g_bad_params
    $error("note_lane_renderer: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_t;

  localparam logic [1:0] CODE_BLACK  = 2'b00;
  localparam logic [1:0] CODE_RED    = 2'b01;
  localparam logic [1:0] CODE_YELLOW = 2'b10;
  localparam logic [3:0] SLOT_LAST   = 4'(NUM_SLOTS - 1);
  localparam logic [2:0] PX_LAST     = 3'(SQ_SIZE - 1);

  state_t      state_q, state_d;
  logic [3:0]  slot_q, slot_d;
  logic [2:0]  px_q, px_d, py_q, py_d;
  logic [15:0] red_q, red_d, yel_q, yel_d;
  logic        plot_q, plot_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  colour_q, colour_d;
  logic [1:0]  code_nxt;
  logic        skip_cur, skip_nxt, slot_end;

`ifdef NOTE_LANE_DIFF_EN
  logic [15:0][1:0] hist_q, hist_d;
`endif

  function automatic logic [1:0] slot_code(input logic [15:0] r, input logic [15:0] yl,
                                           input logic [3:0] s);
    if (r[s])       return CODE_RED;
    else if (yl[s]) return CODE_YELLOW;
    else            return CODE_BLACK;
  endfunction

  function automatic logic [2:0] colour_of(input logic [1:0] c);
    case (c)
      CODE_RED:    return 3'b100;
      CODE_YELLOW: return 3'b110;
      default:     return 3'b000;
    endcase
  endfunction

  // Output registers are loaded from the next-state counters so each pixel
  // appears in the same cycle its DRAW state is entered (first plot two cycles after start).
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    px_d     = px_q;
    py_d     = py_q;
    red_d    = red_q;
    yel_d    = yel_q;
    skip_cur = 1'b0;
    skip_nxt = 1'b0;
`ifdef NOTE_LANE_DIFF_EN
    hist_d   = hist_q;
    skip_cur = (state_q == S_DRAW) && (hist_q[slot_q] == slot_code(red_q, yel_q, slot_q));
`endif
    slot_end = skip_cur || (px_q == PX_LAST && py_q == PX_LAST);

    case (state_q)
      S_IDLE: if (bus.start) state_d = S_LOAD;
      S_LOAD: begin
        red_d   = 16'(bus.red_sequence);
        yel_d   = 16'(bus.yellow_sequence);
        slot_d  = '0;
        px_d    = '0;
        py_d    = '0;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        if (slot_end) begin
          px_d = '0;
          py_d = '0;
          if (slot_q == SLOT_LAST) state_d = S_DONE;
          else                     slot_d  = slot_q + 4'd1;
        end else if (px_q == PX_LAST) begin
          px_d = '0;
          py_d = py_q + 3'd1;
        end else begin
          px_d = px_q + 3'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    code_nxt = slot_code(red_d, yel_d, slot_d);
`ifdef NOTE_LANE_DIFF_EN
    if (state_q == S_DRAW && slot_end) hist_d[slot_q] = slot_code(red_q, yel_q, slot_q);
    skip_nxt = (hist_q[slot_d] == code_nxt);
`endif

    plot_d   = (state_d == S_DRAW) && !skip_nxt;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    if (plot_d) begin
      x_d      = 8'(X_START + 32'(slot_d) * X_PITCH + 32'(px_d));
      y_d      = 7'(Y_POS + 32'(py_d));
      colour_d = colour_of(code_nxt);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      slot_q   <= '0;
      px_q     <= '0;
      py_q     <= '0;
      red_q    <= '0;
      yel_q    <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      px_q     <= px_d;
      py_q     <= py_d;
      red_q    <= red_d;
      yel_q    <= yel_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
    end
  end

`ifdef NOTE_LANE_DIFF_EN
  // All-ones is the "never drawn" code, so the first frame after reset paints every slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) hist_q <= '1;
    else         hist_q <= hist_d;
  end
`endif

  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;

endmodule

// File: tb/tb_note_lane_renderer.sv
// Scoreboard bench for note_lane_renderer: default lane plus a small 3-slot instance.
module tb_note_lane_renderer;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  note_lane_renderer_if #(.NUM_SLOTS(10)) bus ();
  note_lane_renderer_if #(.NUM_SLOTS(3))  bus5 ();

  note_lane_renderer #(
    .NUM_SLOTS(10), .SQ_SIZE(4), .X_START(10), .X_PITCH(10), .Y_POS(112)
  ) u_dut (
    .clk(clk), .resetn(resetn), .bus(bus.slave)
  );

  note_lane_renderer #(
    .NUM_SLOTS(3), .SQ_SIZE(2), .X_START(0), .X_PITCH(2), .Y_POS(112)
  ) u_p5 (
    .clk(clk), .resetn(resetn), .bus(bus5.slave)
  );

`ifdef NOTE_LANE_DIFF_EN
  localparam int T2_PLOTS = 144;
  localparam int T3_PLOTS = 80;
  localparam int T6B_PLOTS = 0;
  localparam int T6C_PLOTS = 16;
  logic [1:0] mhist [10];
`else
  localparam int T2_PLOTS = 160;
  localparam int T3_PLOTS = 160;
  localparam int T6B_PLOTS = 160;
  localparam int T6C_PLOTS = 160;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [17:0] exp_q [$];
  logic [17:0] exp5_q [$];
  logic [17:0] got, exp_e, got5, exp5_e, first_pix, last_pix;
  int plot_cnt = 0, done_cnt = 0, first_cyc = 0, last_cyc = 0, done_cyc = 0;
  int cnt5 = 0, done5 = 0;
  logic prev_plot = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.plot === 1'b1) begin
      got = {bus.x, bus.y, bus.colour};
      if (!prev_plot) begin
        first_cyc = cyc;
        first_pix = got;
      end
      last_cyc = cyc;
      last_pix = got;
      plot_cnt++;
      if (exp_q.size() == 0) check("scoreboard_empty", 32'(exp_q.size()), 1);
      else begin
        exp_e = exp_q.pop_front();
        check("pixel", 32'(got), 32'(exp_e));
      end
    end
    prev_plot = (bus.plot === 1'b1);
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (bus5.plot === 1'b1) begin
      got5 = {bus5.x, bus5.y, bus5.colour};
      cnt5++;
      if (exp5_q.size() == 0) check("p5_scoreboard_empty", 32'(exp5_q.size()), 1);
      else begin
        exp5_e = exp5_q.pop_front();
        check("p5_pixel", 32'(got5), 32'(exp5_e));
      end
    end
    if (bus5.done === 1'b1) done5++;
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic push_frame(input logic [9:0] r, input logic [9:0] yl);
    logic [2:0] col;
    for (int s = 0; s < 10; s++) begin
      col = r[s] ? 3'b100 : (yl[s] ? 3'b110 : 3'b000);
`ifdef NOTE_LANE_DIFF_EN
      if (mhist[s] == (r[s] ? 2'd1 : (yl[s] ? 2'd2 : 2'd0))) continue;
      mhist[s] = r[s] ? 2'd1 : (yl[s] ? 2'd2 : 2'd0);
`endif
      for (int py = 0; py < 4; py++)
        for (int px = 0; px < 4; px++)
          exp_q.push_back({8'(10 + 10 * s + px), 7'(112 + py), col});
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
`ifdef NOTE_LANE_DIFF_EN
    for (int s = 0; s < 10; s++) mhist[s] = 2'b11;
`endif
    repeat (3) step();
    resetn = 1'b1;
    step();
  endtask

  task automatic run_frame(input string tag, input logic [9:0] r, input logic [9:0] yl,
                           input int exp_plots, input bit poke);
    int p0, d0, s_cyc;
    push_frame(r, yl);
    p0 = plot_cnt;
    d0 = done_cnt;
    bus.red_sequence    = r;
    bus.yellow_sequence = yl;
    bus.start           = 1'b1;
    s_cyc               = cyc;
    step();
    bus.start = 1'b0;
    check({tag, "_load_busy"}, 32'(bus.busy), 1);
    check({tag, "_load_plot"}, 32'(bus.plot), 0);
    for (int i = 0; i < 400 && done_cnt == d0; i++) begin
      if (poke && i == 20) begin
        bus.red_sequence    = ~r;
        bus.yellow_sequence = ~yl;
        bus.start           = 1'b1;
      end
      if (poke && i == 23) bus.start = 1'b0;
      step();
    end
    step();
    check({tag, "_done_once"}, 32'(done_cnt - d0), 1);
    check({tag, "_plots"}, 32'(plot_cnt - p0), 32'(exp_plots));
    if (exp_plots == 160) begin
      check({tag, "_first_latency"}, 32'(first_cyc - s_cyc), 2);
      check({tag, "_done_after_last"}, 32'(done_cyc - last_cyc), 1);
    end
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
    check({tag, "_idle_busy"}, 32'(bus.busy), 0);
  endtask

  int xs5 [12] = '{0, 1, 0, 1, 2, 3, 2, 3, 4, 5, 4, 5};
  int ys5 [12] = '{112, 112, 113, 113, 112, 112, 113, 113, 112, 112, 113, 113};

  initial begin
    int p0, d0;
    logic [2:0] col5;
    bus.start = 1'b0;  bus.red_sequence = '0;  bus.yellow_sequence = '0;
    bus5.start = 1'b0; bus5.red_sequence = '0; bus5.yellow_sequence = '0;
    do_reset();
    resetn = 1'b0;
    step();
    check("rst_plot",   32'(bus.plot), 0);
    check("rst_busy",   32'(bus.busy), 0);
    check("rst_done",   32'(bus.done), 0);
    check("rst_xy",     32'({bus.x, bus.y}), 0);
    check("rst_colour", 32'(bus.colour), 0);
    check("rst_p5_plot", 32'(bus5.plot), 0);
    resetn = 1'b1;
    step();

    // 1: default pattern
    run_frame("t1", 10'h001, 10'h002, 160, 1'b0);
    check("t1_first_pix", 32'(first_pix), 32'({8'd10, 7'd112, 3'b100}));
    check("t1_last_pix",  32'(last_pix),  32'({8'd103, 7'd115, 3'b000}));

    // 2: red beats yellow
    run_frame("t2", 10'h3FF, 10'h3FF, T2_PLOTS, 1'b0);

    // 3: inputs and start changed mid-frame
    run_frame("t3", 10'h2AA, 10'h155, T3_PLOTS, 1'b1);
    p0 = plot_cnt;
    d0 = done_cnt;
    repeat (10) step();
    check("t3_no_restart_plot", 32'(plot_cnt - p0), 0);
    check("t3_no_restart_done", 32'(done_cnt - d0), 0);
    check("t3_no_restart_busy", 32'(bus.busy), 0);

    // 4: reset in the middle of a frame
    push_frame(10'h3FF, 10'h000);
    p0 = plot_cnt;
    bus.red_sequence = 10'h3FF; bus.yellow_sequence = 10'h000; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 300 && (plot_cnt - p0) < 50; i++) step();
    check("t4_reached_50", 32'(plot_cnt - p0), 50);
    d0 = done_cnt;
    resetn = 1'b0;
    #1;
    check("t4_rst_plot",   32'(bus.plot), 0);
    check("t4_rst_busy",   32'(bus.busy), 0);
    check("t4_rst_colour", 32'(bus.colour), 0);
    check("t4_rst_xy",     32'({bus.x, bus.y}), 0);
    exp_q.delete();
    do_reset();
    repeat (10) step();
    check("t4_no_done", 32'(done_cnt - d0), 0);
    run_frame("t4_fresh", 10'h3FF, 10'h000, 160, 1'b0);

    // 6: repeated frames (history skip when enabled)
    do_reset();
    run_frame("t6a", 10'h001, 10'h000, 160, 1'b0);
    run_frame("t6b", 10'h001, 10'h000, T6B_PLOTS, 1'b0);
    run_frame("t6c", 10'h003, 10'h000, T6C_PLOTS, 1'b0);

    // 5: small lane geometry
    for (int i = 0; i < 12; i++) begin
      col5 = (i < 4) ? 3'b100 : ((i < 8) ? 3'b110 : 3'b000);
      exp5_q.push_back({8'(xs5[i]), 7'(ys5[i]), col5});
    end
    d0 = done5;
    bus5.red_sequence = 3'b001; bus5.yellow_sequence = 3'b010; bus5.start = 1'b1;
    step();
    bus5.start = 1'b0;
    for (int i = 0; i < 100 && done5 == d0; i++) step();
    step();
    check("t5_plots", 32'(cnt5), 12);
    check("t5_done_once", 32'(done5 - d0), 1);
    check("t5_queue_empty", 32'(exp5_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
